count_seq_checker: RTL

- Downstream consumer of the free-running counter block: samples its count output every clock and checks that successive values are +1 modulo 2^W.
- Reports wrap-around events, sequence errors and a lock status.
- Used as an in-design monitor alongside the counter and as a self-checking element in counter benches; never drives the counter.

---
 rtl/count_seq_checker_pkg.sv | 16 +
 rtl/count_seq_checker_sat_counter.sv | 26 ++
 rtl/count_seq_checker.sv | 130 +++++++++++++
 3 files changed

// File: rtl/count_seq_checker_pkg.sv
// Shared definitions for the count sequence checker and any counter bench that
// wants to decode its debug state output.
package count_seq_checker_pkg;

  localparam int STATE_W  = 2;
  // Streak counter width covers the largest legal LOCK_N (255).
  localparam int STREAK_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_UNUSED = 2'd3
  } state_e;

endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones, clears on
// synchronous reset.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] r_value;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff reads the pre-edge values of all registers regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
    end else if (inc && (r_value != '1)) begin
      r_value <= r_value + WIDTH'(1);
    end
  end

  assign value = r_value;

endmodule

// File: rtl/count_seq_checker.sv
// Monitors a free-running counter: checks each valid sample is the previous
// one plus 1 (mod 2^W), tracks lock, and reports wraps and sequence breaks.
module count_seq_checker
  import count_seq_checker_pkg::*;
#(
  parameter int W      = 4,
  parameter int LOCK_N = 4,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W-1:0]       count_in,
  input  logic               count_valid,
  output logic               locked,
  output logic               wrap_pulse,
  output logic               err_pulse,
  output logic [CNT_W-1:0]   wrap_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [STATE_W-1:0] state
);

  state_e              r_state;
  logic [W-1:0]        r_prev;
  logic [STREAK_W-1:0] r_streak;
  logic                r_locked;
  logic                r_wrap_pulse;
  logic                r_err_pulse;

  logic [W-1:0]        w_expected;
  logic [STREAK_W-1:0] w_streak_inc;
  logic                w_correct;
  logic                w_prev_max;
  logic                w_tracking;
  logic                w_wrap_evt;
  logic                w_err_evt;
  logic                w_lock_evt;

  // Truncation to W bits makes the all-ones -> 0 step a correct increment.
  assign w_expected   = r_prev + W'(1);
  assign w_correct    = (count_in == w_expected);
  assign w_prev_max   = (r_prev == '1);
  assign w_streak_inc = r_streak + STREAK_W'(1);

  // Comparisons only mean something once a previous sample has been captured.
  assign w_tracking = count_valid && ((r_state == ST_ACQ) || (r_state == ST_LOCKED));
  assign w_wrap_evt = w_tracking && w_correct && w_prev_max;
  assign w_err_evt  = count_valid && (r_state == ST_LOCKED) && !w_correct;
  assign w_lock_evt = count_valid && (r_state == ST_ACQ) && w_correct
                      && (w_streak_inc == STREAK_W'(LOCK_N));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_prev       <= '0;
      r_streak     <= '0;
      r_locked     <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_err_pulse  <= 1'b0;
    end else begin
      r_wrap_pulse <= w_wrap_evt;
      r_err_pulse  <= w_err_evt;

      if (count_valid) begin
        r_prev <= count_in;
      end

      if (!count_valid) begin
        // Upstream not running: drop back and re-acquire from scratch.
        r_state  <= ST_IDLE;
        r_locked <= 1'b0;
        r_streak <= '0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_streak <= STREAK_W'(1);
            r_state  <= ST_ACQ;
          end
          ST_ACQ: begin
            if (w_correct) begin
              r_streak <= w_streak_inc;
              if (w_lock_evt) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              // The mismatching sample becomes the new base of the streak.
              r_streak <= STREAK_W'(1);
            end
          end
          ST_LOCKED: begin
            if (!w_correct) begin
              r_locked <= 1'b0;
              r_streak <= STREAK_W'(1);
              r_state  <= ST_ACQ;
            end
          end
          default: begin
            r_state  <= ST_IDLE;
            r_locked <= 1'b0;
            r_streak <= '0;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_wrap_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_wrap_evt),
    .value (wrap_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_err_evt),
    .value (err_cnt)
  );

  assign locked     = r_locked;
  assign wrap_pulse = r_wrap_pulse;
  assign err_pulse  = r_err_pulse;
  assign state      = r_state;

endmodule
